// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared types for the multicycle multiply/divide unit.
//   mdu_op_t    : operation code sampled with start
//   mdu_state_t : FSM state encoding, also exported on mdu_state
// Optional feature macro used by the unit: MULTDIV_DIV_EN (divide support).
// ---------------------------------------------------------------------------
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } mdu_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_REJ  = 2'd3
   } mdu_state_t;

   // True for the two operations that use the divide datapath.
   function automatic logic op_is_div(input mdu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the two operations with two's-complement operands.
   function automatic logic op_is_signed(input mdu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the control FSM (master) and the
// multiply/divide unit (slave).
//   start, op, a, b          : request, sampled by the unit while idle
//   busy, done, err, hi, lo  : status and HI/LO result
//   mdu_state                : current unit FSM state (debug)
// ---------------------------------------------------------------------------
interface mult_div_unit_if
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             start;
   mdu_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             err;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   mdu_state_t       mdu_state;

   modport master (output start, op, a, b,
                   input  busy, done, err, hi, lo, mdu_state);
   modport slave  (input  start, op, a, b,
                   output busy, done, err, hi, lo, mdu_state);
endinterface

// File: rtl/mult_div_unit_addsub.sv
// ---------------------------------------------------------------------------
// mdu_addsub
// (WIDTH+1)-bit adder/subtractor shared by the multiply and divide
// iterations.
//   x_i, y_i : operands
//   sub_i    : 0 = x+y, 1 = x-y (x + ~y + 1)
//   res_o    : result
//   cout_o   : carry out; for subtraction 1 means "no borrow"
// ---------------------------------------------------------------------------
module mdu_addsub #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] x_i,
   input  logic [WIDTH:0] y_i,
   input  logic           sub_i,
   output logic [WIDTH:0] res_o,
   output logic           cout_o
);
   logic [WIDTH:0] y_eff_s;

   // Operand inversion plus carry-in turns the adder into a subtractor.
   always_comb begin
      y_eff_s         = sub_i ? ~y_i : y_i;
      {cout_o, res_o} = {1'b0, x_i} + {1'b0, y_eff_s} + {{(WIDTH + 1){1'b0}}, sub_i};
   end
endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative radix-2 multiply/divide unit producing HI/LO, one bit per clock.
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : mult_div_unit_if.slave (start/op/a/b in; busy/done/err/hi/lo/
//              mdu_state out)
// Macro MULTDIV_DIV_EN: when defined DIV/DIVU are executed; when undefined
// the divide datapath is absent and DIV/DIVU are rejected with err.
// ---------------------------------------------------------------------------
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          Clk,
   input  logic          Reset_n,
   mult_div_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   mdu_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;   // mult: upper product half; div: remainder
   logic [WIDTH-1:0]   mq_q, mq_d;     // mult: multiplier/low half; div: dividend/quotient
   logic [WIDTH-1:0]   md_q, md_d;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_lo_q, neg_lo_d; // negate product / quotient
   logic               neg_hi_q, neg_hi_d; // negate remainder
   logic               done_q, done_d, err_q, err_d;

   logic [WIDTH:0]     as_x_s, as_y_s, as_res_s;
   logic               as_sub_s, as_cout_s;
   logic               reject_s;
   logic [2*WIDTH-1:0] prod_s;

   mdu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .x_i    (as_x_s),
      .y_i    (as_y_s),
      .sub_i  (as_sub_s),
      .res_o  (as_res_s),
      .cout_o (as_cout_s)
   );

`ifndef MULTDIV_DIV_EN
   // Carry out only matters for the divide's borrow test.
   logic unused_cout_s;
   assign unused_cout_s = as_cout_s;
`endif

   // Adder operand selection for the current iteration.
   always_comb begin
      as_sub_s = 1'b0;
      as_x_s   = {1'b0, acc_q};
      if (mq_q[0]) begin
         as_y_s = {1'b0, md_q};
      end else begin
         as_y_s = {(WIDTH + 1){1'b0}};
      end
`ifdef MULTDIV_DIV_EN
      // Restoring divide: trial-subtract divisor from remainder shifted left
      // by one with the next dividend bit.
      if (is_div_q) begin
         as_sub_s = 1'b1;
         as_x_s   = {acc_q, mq_q[WIDTH-1]};
         as_y_s   = {1'b0, md_q};
      end else begin
         as_sub_s = 1'b0;
      end
`endif
   end

   // Divide by zero always rejects; without divide support any divide does.
   always_comb begin
`ifdef MULTDIV_DIV_EN
      reject_s = op_is_div(bus.op) && (bus.b == {WIDTH{1'b0}});
`else
      reject_s = op_is_div(bus.op);
`endif
   end

   assign prod_s = {acc_q, mq_q};

   // Next-state, datapath and result logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mq_d     = mq_q;
      md_d     = md_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end else if (reject_s) begin
               state_d = S_REJ;
            end else begin
               state_d  = S_CALC;
               cnt_d    = CNT_W'(WIDTH);
               acc_d    = {WIDTH{1'b0}};
               is_div_d = op_is_div(bus.op);
               neg_lo_d = op_is_signed(bus.op) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               neg_hi_d = op_is_signed(bus.op) && bus.a[WIDTH-1];
               if (op_is_div(bus.op)) begin
                  mq_d = (op_is_signed(bus.op) && bus.a[WIDTH-1]) ? -bus.a : bus.a;
                  md_d = (op_is_signed(bus.op) && bus.b[WIDTH-1]) ? -bus.b : bus.b;
               end else begin
                  mq_d = (op_is_signed(bus.op) && bus.b[WIDTH-1]) ? -bus.b : bus.b;
                  md_d = (op_is_signed(bus.op) && bus.a[WIDTH-1]) ? -bus.a : bus.a;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - {{(CNT_W - 1){1'b0}}, 1'b1};
`ifdef MULTDIV_DIV_EN
            if (is_div_q) begin
               if (as_cout_s) begin
                  acc_d = as_res_s[WIDTH-1:0];
               end else begin
                  acc_d = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
               end
               mq_d = {mq_q[WIDTH-2:0], as_cout_s};
            end else begin
               acc_d = as_res_s[WIDTH:1];
               mq_d  = {as_res_s[0], mq_q[WIDTH-1:1]};
            end
`else
            acc_d = as_res_s[WIDTH:1];
            mq_d  = {as_res_s[0], mq_q[WIDTH-1:1]};
`endif
            if (cnt_q == {{(CNT_W - 1){1'b0}}, 1'b1}) begin
               state_d = S_FIX;
            end else begin
               state_d = S_CALC;
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef MULTDIV_DIV_EN
            if (is_div_q) begin
               lo_d = neg_lo_q ? -mq_q : mq_q;
               hi_d = neg_hi_q ? -acc_q : acc_q;
            end else begin
               {hi_d, lo_d} = neg_lo_q ? -prod_s : prod_s;
            end
`else
            {hi_d, lo_d} = neg_lo_q ? -prod_s : prod_s;
`endif
         end
         S_REJ: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         mq_q     <= {WIDTH{1'b0}};
         md_q     <= {WIDTH{1'b0}};
         hi_q     <= {WIDTH{1'b0}};
         lo_q     <= {WIDTH{1'b0}};
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mq_q     <= mq_d;
         md_q     <= md_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.mdu_state = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed and random operations on mult_div_unit (WIDTH=32) compared
// against an arithmetic reference model of HI/LO, err, latency and busy.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
   import mdu_pkg::*;

`ifdef MULTDIV_DIV_EN
   localparam bit DIV_SUPPORTED = 1'b1;
`else
   localparam bit DIV_SUPPORTED = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;
   logic [31:0] mhi;
   logic [31:0] mlo;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: results from plain arithmetic; rejected ops keep HI/LO.
   function automatic void model(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic err, output logic rej);
      longint      sa, sb, q, r;
      logic [63:0] p;
      hi  = mhi;
      lo  = mlo;
      err = 1'b0;
      rej = 1'b0;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      case (op)
         OP_MULTU: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         OP_MULT: begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
         end
         default: begin
            if (b == 32'd0 || !DIV_SUPPORTED) begin
               err = 1'b1;
               rej = 1'b1;
            end else if (op == OP_DIV) begin
               q  = sa / sb;
               r  = sa % sb;
               lo = 32'(q);
               hi = 32'(r);
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
      endcase
   endfunction

   // Issue one op (start held over the next edge), optionally pulse a second
   // start during the run, then wait for done and check everything.
   task automatic run_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at);
      logic [31:0] ehi, elo;
      logic        eerr, erej;
      int          cyc, bcyc, exp_lat;
      model(op, a, b, ehi, elo, eerr, erej);
      exp_lat   = erej ? 1 : 33;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc  = 0;
      bcyc = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         if (bus.busy === 1'b1) bcyc++;
         if (glitch_at > 0 && cyc == glitch_at) begin
            bus.start = 1'b1;
            bus.a     = $urandom;
            bus.b     = $urandom;
            bus.op    = mdu_op_t'($urandom_range(0, 3));
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start = 1'b0;
      chk("latency", 64'(cyc), 64'(exp_lat));
      chk("busy_cycles", 64'(bcyc), 64'(exp_lat));
      chk("busy_at_done", 64'(bus.busy), 64'd0);
      chk("state_at_done", 64'(bus.mdu_state), 64'(S_IDLE));
      chk("err", 64'(bus.err), 64'(eerr));
      chk("hi", 64'(bus.hi), 64'(ehi));
      chk("lo", 64'(bus.lo), 64'(elo));
      mhi = ehi;
      mlo = elo;
   endtask

   initial begin
      logic [31:0] ra, rb;
      n_cmp     = 0;
      n_fail    = 0;
      mhi       = 32'd0;
      mlo       = 32'd0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      chk("rst_state", 64'(bus.mdu_state), 64'(S_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Largest unsigned product.
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      chk("t1_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
      chk("t1_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
      // Signed product with differing signs (issued in the done cycle).
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
      chk("t2_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
      chk("t2_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
      // Divides, including the MIN / -1 wrap.
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      if (DIV_SUPPORTED) begin
         chk("t3a_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
         chk("t3a_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
      end else begin
         chk("t3a_rej", 64'(bus.err), 64'd1);
      end
      run_op(OP_DIVU, 32'd100, 32'd7, 0);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      // Divide by zero keeps HI/LO.
      run_op(OP_DIV, 32'd55, 32'd0, 0);
      run_op(OP_DIVU, 32'd100, 32'd7, 0);
      // Start pulsed mid-operation is ignored.
      run_op(OP_MULTU, 32'd123456, 32'd654321, 5);
      run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5);

      // Reset in the middle of an operation.
      bus.op    = OP_MULTU;
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'h1234_5678;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_hi", 64'(bus.hi), 64'd0);
      chk("midrst_lo", 64'(bus.lo), 64'd0);
      chk("midrst_state", 64'(bus.mdu_state), 64'(S_IDLE));
      mhi = 32'd0;
      mlo = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(OP_MULTU, 32'd6, 32'd7, 0);
      chk("t6_lo", 64'(bus.lo), 64'd42);

      // Random operations, some with zero or small divisors.
      for (int i = 0; i < 14; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 9));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op(mdu_op_t'($urandom_range(0, 3)), ra, rb, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
